// File: rtl/button_decoder_if.sv
// Button front-end bus: raw key lines in, ready pulse, button code and random colour out.
interface button_decoder_if;
    logic [4:0] BTN_RAW;
    logic       R;
    logic [2:0] B;
    logic [1:0] C;

    modport master (output BTN_RAW, input R, B, C);
    modport slave  (input BTN_RAW, output R, B, C);
endinterface

// File: rtl/button_decoder.sv
// Synchronises and debounces five raw buttons, emits a one-cycle ready pulse with a stable code,
// and hands out a fresh LFSR colour with every accepted press.
module button_decoder #(
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic            CLK,
    input  logic            RESET_N,
    button_decoder_if.slave bus
);
    localparam int                CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0]       SEED    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 in a right-shifting register
    localparam logic [15:0]       TAPS    = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        DEB_REL
    } state_t;

    function automatic logic is_onehot(input logic [4:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

    function automatic logic [2:0] btn_code(input logic [4:0] v);
        logic [2:0] code;
        case (v)
            5'b00001: code = 3'd1;
            5'b00010: code = 3'd2;
            5'b00100: code = 3'd3;
            5'b01000: code = 3'd4;
            5'b10000: code = 3'd6;
            default:  code = 3'd0;
        endcase
        return code;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic [4:0]       btn_in;
    logic [4:0]       sync_p0;
    logic [4:0]       sync_p1;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [4:0]       cap_q;
    logic [4:0]       cap_d;
    logic             vld_p2;
    logic             vld_d;
    logic [2:0]       code_p2;
    logic [2:0]       code_d;
    logic [1:0]       colour_p2;
    logic [1:0]       colour_d;
    logic [15:0]      lfsr_q;

    assign btn_in = ACTIVE_LOW ? ~bus.BTN_RAW : bus.BTN_RAW;

    // Stage p0/p1: two-flop synchroniser, 1 = pressed; the LFSR free-runs alongside
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_p0 <= 5'd0;
            sync_p1 <= 5'd0;
            lfsr_q  <= SEED;
        end else begin
            sync_p0 <= btn_in;
            sync_p1 <= sync_p0;
            lfsr_q  <= lfsr_step(lfsr_q);
        end
    end

    // Stage p2: debounce FSM state and registered outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cap_q     <= 5'd0;
            vld_p2    <= 1'b0;
            code_p2   <= 3'd0;
            colour_p2 <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cap_q     <= cap_d;
            vld_p2    <= vld_d;
            code_p2   <= code_d;
            colour_p2 <= colour_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cap_d    = cap_q;
        vld_d    = 1'b0;
        code_d   = code_p2;
        colour_d = colour_p2;
        case (state_q)
            IDLE: begin
                if (is_onehot(sync_p1)) begin
                    cap_d   = sync_p1;
                    cnt_d   = '0;
                    state_d = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (sync_p1 != cap_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = PRESSED;
                    vld_d    = 1'b1;
                    code_d   = btn_code(cap_q);
                    colour_d = lfsr_q[1:0];
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            PRESSED: begin
                // Extra buttons are ignored; only a full release moves on
                if (sync_p1 == 5'd0) begin
                    cnt_d   = '0;
                    state_d = DEB_REL;
                end
            end
            DEB_REL: begin
                if (sync_p1 != 5'd0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    code_d  = 3'd0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.R = vld_p2;
    assign bus.B = code_p2;
    assign bus.C = colour_p2;
endmodule
